unidad_mul_div: RTL

Iterative multiply/divide unit directly downstream of the register file.
- Consumes the two register read values (data_register_1 → operand_a, data_register_2 → operand_b) when start is asserted.
- Computes a 64-bit product, or a quotient/remainder, over a fixed 34-cycle latency.
- Holds the result in HI/LO registers for later move-from-HI/LO instructions.
- Sits beside the ALU in the execute stage; the control unit stalls on busy.

---
 rtl/unidad_mul_div_pkg.sv | 28 ++
 rtl/unidad_mul_div_if.sv | 28 ++
 rtl/unidad_mul_div_step.sv | 41 ++++
 rtl/unidad_mul_div.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/unidad_mul_div_pkg.sv
// rtl/unidad_mul_div_pkg.sv - shared types and constants for the multiply/divide unit
// Contents: op encodings, FSM state encoding, default operand width, op decode helpers.
package mul_div_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

    function automatic logic is_signed_op(input op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div_op(input op_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/unidad_mul_div_if.sv
// rtl/unidad_mul_div_if.sv - request/result bundle between execute-stage control and the mul/div unit
// master: drives start, op, operand_a, operand_b; observes busy, done, div_by_zero, hi, lo.
// slave:  the unit itself, the mirror image.
interface unidad_mul_div_if
    import mul_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/unidad_mul_div_step.sv
// rtl/unidad_mul_div_step.sv - one combinational shift-add / restoring shift-subtract iteration
// Ports: mode_div (0 multiply, 1 divide), acc {upper, lower} working register,
//        operand (multiplicand or divisor magnitude), acc_next, q_bit (divide only).
// In divide mode acc_next leaves its LSB at 0; the caller inserts q_bit there.
module mul_div_step
    import mul_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               mode_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);
    localparam int AW = 2 * WIDTH;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic [WIDTH:0]   rem_new;

    always_comb begin
        // Multiply: add multiplicand to the upper half when the current multiplier bit is set,
        // then shift the whole register right; the carry enters at the top.
        sum     = {1'b0, acc[AW-1:WIDTH]} + {1'b0, (acc[0] ? operand : '0)};
        // Divide: shift the next dividend bit into the partial remainder and trial-subtract.
        rem_sh  = {acc[AW-1:WIDTH], acc[WIDTH-1]};
        diff    = {1'b0, rem_sh} - {2'b00, operand};
        q_bit   = 1'b0;
        rem_new = rem_sh;
        if (mode_div) begin
            q_bit    = ~diff[WIDTH+1];
            rem_new  = q_bit ? diff[WIDTH:0] : rem_sh;
            // Remainder stays below the divisor, so its top bit is always zero and dropped.
            acc_next = AW'({rem_new, acc[WIDTH-2:0], 1'b0});
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/unidad_mul_div.sv
// rtl/unidad_mul_div.sv - iterative 32-step multiply/divide unit with HI/LO result registers
// Ports: clk, rst_n (async active-low), bus (slave): start/op/operand_a/operand_b in;
//        busy, done (1-cycle), div_by_zero (sticky until next accepted start), hi, lo out.
module unidad_mul_div
    import mul_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    unidad_mul_div_if.slave   bus
);
    localparam int ITER  = WIDTH;
    localparam int CNT_W = $clog2(ITER);
    localparam int AW    = 2 * WIDTH;

    state_t             state, state_next;
    op_t                op_q;
    logic               sign_a, sign_b;
    logic               b_zero;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   divisor;
    logic [AW-1:0]      acc;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, dz_q;

    logic [AW-1:0]      step_acc;
    logic               step_q;
    logic               in_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [AW-1:0]      prod;
    logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

    mul_div_step #(.WIDTH(WIDTH)) u_step (
        .mode_div (is_div_op(op_q)),
        .acc      (acc),
        .operand  (divisor),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        bus.busy   = 1'b0;
        case (state)
            IDLE: if (bus.start) state_next = CALC;
            CALC: begin
                bus.busy = 1'b1;
                if (count == '0) state_next = FIX;
            end
            FIX: begin
                bus.busy   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_signed = is_signed_op(op_t'(bus.op));
        mag_a = (in_signed && bus.operand_a[WIDTH-1]) ? -bus.operand_a : bus.operand_a;
        mag_b = (in_signed && bus.operand_b[WIDTH-1]) ? -bus.operand_b : bus.operand_b;
    end

    // Sign correction on the unsigned magnitudes; divide-by-zero overrides the divide outputs.
    always_comb begin
        prod = (op_q == OP_MULT && (sign_a ^ sign_b)) ? -acc : acc;
        quo  = acc[WIDTH-1:0];
        rem  = acc[AW-1:WIDTH];
        if (op_q == OP_DIV) begin
            if (sign_a ^ sign_b) quo = -quo;
            if (sign_a)          rem = -rem;
        end
        if (b_zero) begin
            quo = '1;
            rem = a_raw;
        end
        if (is_div_op(op_q)) begin
            res_hi = rem;
            res_lo = quo;
        end else begin
            res_hi = prod[AW-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_MULT;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            b_zero  <= 1'b0;
            a_raw   <= '0;
            divisor <= '0;
            acc     <= '0;
            count   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    op_q    <= op_t'(bus.op);
                    sign_a  <= in_signed & bus.operand_a[WIDTH-1];
                    sign_b  <= in_signed & bus.operand_b[WIDTH-1];
                    b_zero  <= (bus.operand_b == '0);
                    a_raw   <= bus.operand_a;
                    divisor <= mag_b;
                    acc     <= {{WIDTH{1'b0}}, mag_a};
                    count   <= CNT_W'(ITER - 1);
                    dz_q    <= 1'b0;
                end
                CALC: begin
                    // Quotient bit fills the LSB vacated by the shift.
                    acc   <= step_acc | {{(AW-1){1'b0}}, step_q};
                    count <= count - 1'b1;
                end
                FIX: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                    dz_q   <= is_div_op(op_q) & b_zero;
                end
                default: ;
            endcase
        end
    end

    assign bus.done        = done_q;
    assign bus.div_by_zero = dz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule
